// File: rtl/vc_tdm_mux_sec.sv
// N-port time-division-multiplexed valid/ready mux; a free-running slot counter alone picks the output port.
// Optional build macro VC_TDM_MUX_GUARD_EN turns the last cycle of each slot into a no-dequeue guard cycle.
module vc_tdm_mux_sec #(
  parameter int p_nbits       = 32,
  parameter int p_nports      = 4,
  parameter int p_depth       = 2,
  parameter int p_slot_cycles = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [p_nports-1:0]           in_val,
  output logic [p_nports-1:0]           in_rdy,
  input  logic [p_nports*p_nbits-1:0]   in_msg,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [p_nbits-1:0]            out_msg,
  output logic [$clog2(p_nports)-1:0]   out_port,
  output logic                          slot_last
);

  localparam int SW   = $clog2(p_nports);
  localparam int CW   = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
  localparam int PW   = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CNTW = $clog2(p_depth) + 1;

  localparam logic [SW-1:0]   SLOT_MAX = SW'(p_nports - 1);
  localparam logic [CW-1:0]   CYC_MAX  = CW'(p_slot_cycles - 1);
  localparam logic [PW-1:0]   PTR_MAX  = PW'(p_depth - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(p_depth);

`ifdef VC_TDM_MUX_GUARD_EN
  if (p_slot_cycles < 2) begin : g_bad_cfg
    $error("vc_tdm_mux_sec: guard cycle needs p_slot_cycles >= 2");
  end
`endif

  logic [SW-1:0]      slot_q, slot_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [PW-1:0]      wr_ptr_q [p_nports];
  logic [PW-1:0]      wr_ptr_d [p_nports];
  logic [PW-1:0]      rd_ptr_q [p_nports];
  logic [PW-1:0]      rd_ptr_d [p_nports];
  logic [CNTW-1:0]    count_q  [p_nports];
  logic [CNTW-1:0]    count_d  [p_nports];
  logic [p_nbits-1:0] mem_q    [p_nports][p_depth];

  logic [p_nports-1:0] enq, deq, full;
  logic                head_val;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal written here gets a default before any conditional use, so no latch is inferred.
  always_comb begin
    slot_last = (cyc_q == CYC_MAX);
    out_port  = slot_q;
    cyc_d     = slot_last ? '0 : cyc_q + CW'(1);
    slot_d    = slot_q;
    if (slot_last) slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);

    // Only the FIFO owning the current slot is ever looked at for the output side.
    head_val = (count_q[slot_q] != '0);
`ifdef VC_TDM_MUX_GUARD_EN
    out_val  = head_val && !slot_last;
`else
    out_val  = head_val;
`endif
    out_msg  = out_val ? mem_q[slot_q][rd_ptr_q[slot_q]] : '0;

    for (int k = 0; k < p_nports; k++) begin
      deq[k]      = out_val && out_rdy && (slot_q == SW'(k));
      full[k]     = (count_q[k] == CNT_FULL);
      in_rdy[k]   = reset_n && (!full[k] || deq[k]);
      enq[k]      = in_val[k] && in_rdy[k];
      wr_ptr_d[k] = enq[k] ? ptr_inc(wr_ptr_q[k]) : wr_ptr_q[k];
      rd_ptr_d[k] = deq[k] ? ptr_inc(rd_ptr_q[k]) : rd_ptr_q[k];
      count_d[k]  = count_q[k] + CNTW'(enq[k]) - CNTW'(deq[k]);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      cyc_q  <= '0;
      for (int k = 0; k < p_nports; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
    end else begin
      slot_q <= slot_d;
      cyc_q  <= cyc_d;
      for (int k = 0; k < p_nports; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        count_q[k]  <= count_d[k];
      end
    end
  end

  // NOTE: FIFO storage is not reset; the cleared counts make stale contents unreachable.
  always_ff @(posedge clk) begin
    for (int k = 0; k < p_nports; k++) begin
      if (enq[k]) mem_q[k][wr_ptr_q[k]] <= in_msg[k*p_nbits +: p_nbits];
    end
  end

endmodule

// File: tb/tb_vc_tdm_mux_sec.sv
// Self-checking bench for vc_tdm_mux_sec: directed scenarios plus random traffic against a queue-based model.
module tb_vc_tdm_mux_sec;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 2;
  localparam int S = 8;
`ifdef VC_TDM_MUX_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     in_val;
  logic [N-1:0]     in_rdy;
  logic [N*W-1:0]   in_msg;
  logic             out_val;
  logic             out_rdy;
  logic [W-1:0]     out_msg;
  logic [1:0]       out_port;
  logic             slot_last;

  vc_tdm_mux_sec #(.p_nbits(W), .p_nports(N), .p_depth(D), .p_slot_cycles(S)) dut (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_port(out_port),
    .slot_last(slot_last)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: one queue per domain and the cycle count since reset release.
  logic [W-1:0] q [N][$];
  int           t;
  int           m_slot;
  bit           m_ov;
  logic [N-1:0] m_rdy;
  logic [W-1:0] msg [N];
  int           xfers;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  task automatic drive_msgs();
    for (int k = 0; k < N; k++) in_msg[k*W +: W] = msg[k];
  endtask

  // One clock cycle: compare at the negedge, advance the model at the posedge, return at posedge+1.
  task automatic cycle();
    int           cyc;
    bit           last;
    logic [W-1:0] om;
    drive_msgs();
    @(negedge clk);
    if (!reset_n) begin
      for (int k = 0; k < N; k++) q[k].delete();
      t = 0;
      m_ov  = 1'b0;
      m_rdy = '0;
      check("rst_out_port", 64'(out_port), 64'd0);
      check("rst_slot_last", 64'(slot_last), 64'(S == 1));
      check("rst_out_val", 64'(out_val), 64'd0);
      check("rst_out_msg", 64'(out_msg), 64'd0);
      check("rst_in_rdy", 64'(in_rdy), 64'd0);
    end else begin
      cyc    = t % S;
      m_slot = (t / S) % N;
      last   = (cyc == S - 1);
      m_ov   = (q[m_slot].size() > 0) && !(GUARD && last);
      om     = m_ov ? q[m_slot][0] : '0;
      for (int k = 0; k < N; k++)
        m_rdy[k] = (q[k].size() < D) || (m_ov && out_rdy && (k == m_slot));
      check("out_port", 64'(out_port), 64'(m_slot));
      check("slot_last", 64'(slot_last), 64'(last));
      check("out_val", 64'(out_val), 64'(m_ov));
      check("out_msg", 64'(out_msg), 64'(om));
      check("in_rdy", 64'(in_rdy), 64'(m_rdy));
    end
    @(posedge clk);
    if (reset_n) begin
      if (m_ov && out_rdy) begin
        void'(q[m_slot].pop_front());
        xfers++;
      end
      for (int k = 0; k < N; k++)
        if (in_val[k] && m_rdy[k]) q[k].push_back(msg[k]);
      t++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_val  = '0;
    out_rdy = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    in_val  = '0;
    out_rdy = 1'b0;
    for (int k = 0; k < N; k++) msg[k] = '0;
    drive_msgs();
    t = 0;

    // Reset/idle and single-domain latency.
    do_reset();
    #1;
    check("idle_port_c0", 64'(out_port), 64'd0);
    check("idle_last_c0", 64'(slot_last), 64'd0);
    out_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_val = (c == 3) ? 4'b0100 : 4'b0000;
      msg[2] = (c == 3) ? 32'hA5A5_0002 : 32'h0;
      if (c == 7)  check("lit_last_c7", 64'(slot_last), 64'd1);
      if (c == 8)  check("lit_port_c8", 64'(out_port), 64'd1);
      if (c == 15) check("lit_val_c15", 64'(out_val), 64'd0);
      if (c == 16) begin
        check("lit_val_c16", 64'(out_val), 64'd1);
        check("lit_msg_c16", 64'(out_msg), 64'hA5A5_0002);
        check("lit_port_c16", 64'(out_port), 64'd2);
      end
      if (c == 17) check("lit_val_c17", 64'(out_val), 64'd0);
      if (c == 32) check("lit_port_c32", 64'(out_port), 64'd0);
      cycle();
    end

    // Isolation: port 0 fills with downstream stalled; other ports see no effect.
    do_reset();
    out_rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_val[0] = 1'b1;
      in_val[3:1] = 3'($urandom_range(0, 7));
      for (int k = 0; k < N; k++) msg[k] = $urandom;
      if (c == 4) check("lit_iso_rdy0", 64'(in_rdy[0]), 64'd0);
      cycle();
    end

    // Back-to-back through slot 1 with a full FIFO.
    do_reset();
    out_rdy = 1'b1;
    in_val  = 4'b0010;
    for (int c = 0; c < 16; c++) begin
      msg[1] = 32'h1000_0000 + c;
      if (c == 8) begin
        xfers = 0;
        check("lit_b2b_rdy1", 64'(in_rdy[1]), 64'd1);
      end
      cycle();
    end
    check("lit_b2b_count", 64'(xfers), GUARD ? 64'd7 : 64'd8);
    in_val = '0;

    // Boundary dequeue in the final cycle of slot 3.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      in_val  = (c == 0) ? 4'b1000 : 4'b0000;
      msg[3]  = 32'hB0B0_0003;
      out_rdy = (c == 31);
      if (c == 31) check("lit_bnd_val", 64'(out_val), GUARD ? 64'd0 : 64'd1);
      if (c == 32) check("lit_bnd_port", 64'(out_port), 64'd0);
      if (c == 56) check("lit_bnd_left", 64'(out_val), GUARD ? 64'd1 : 64'd0);
      cycle();
    end

    // Reset mid-operation with two messages queued in port 1.
    do_reset();
    out_rdy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_val = (c < 2) ? 4'b0010 : 4'b0000;
      msg[1] = 32'hC0DE_0000 + c;
      cycle();
    end
    reset_n = 1'b0;
    #1;
    check("lit_mid_rdy", 64'(in_rdy), 64'd0);
    check("lit_mid_val", 64'(out_val), 64'd0);
    cycle();
    reset_n = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) check("lit_mid_port", 64'(out_port), 64'd0);
      if (c == 8) check("lit_mid_empty", 64'(out_val), 64'd0);
      cycle();
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_val  = 4'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) msg[k] = $urandom;
      reset_n = ($urandom_range(0, 499) != 0);
      cycle();
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vc_tdm_mux_sec.md
Name: vc_tdm_mux_sec

Overview:
- Parametrised N-input, valid/ready, time-division-multiplexed output mux for security-partitioned datapaths.
- Each input port is its own security domain and owns a per-port FIFO.
- A public slot counter, independent of all data and handshake signals, alone decides which port's FIFO may drive the output, so no domain can modulate another domain's timing.
- Sits between per-domain producers (cache/memory request queues) and a shared downstream channel.

Parameters:
p_nbits, 32, message width in bits
p_nports, 4, number of input ports/domains (>=2)
p_depth, 2, entries per port FIFO (power of 2, >=1)
p_slot_cycles, 8, cycles per time slot (>=1; >=2 when guard enabled)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_val  input  p_nports  per-port message valid
in_rdy  output  p_nports  per-port ready
in_msg  input  p_nports*p_nbits  port k message at bits [k*p_nbits +: p_nbits]
out_val  output  1  output message valid
out_rdy  input  1  downstream ready
out_msg  output  p_nbits  output message
out_port  output  clog2(p_nports)  port owning current slot (public label)
slot_last  output  1  high in final cycle of current slot

Behaviour:
- Reset is asynchronous and active-low.
  - Asserting reset_n=0 at any time clears: every FIFO (pointers and count, contents don't-care), slot index to 0, cycle counter to 0.
  - While reset is held, outputs are: out_val=0, in_rdy=0, out_port=0, slot_last=(p_slot_cycles==1), out_msg=0.
  - Messages in flight at reset are discarded.
- Slot counter:
  - cyc counts 0..p_slot_cycles-1. When cyc==p_slot_cycles-1, cyc returns to 0 and slot advances; slot wraps from p_nports-1 to 0.
  - Advances every cycle unconditionally; it is never stalled by in_val, out_rdy or FIFO state.
  - slot_last=(cyc==p_slot_cycles-1). out_port=slot.
- Enqueue:
  - in_rdy[k]=!full[k] || deq_k, where deq_k=out_val && out_rdy && slot==k.
  - Enqueue into FIFO k when in_val[k] && in_rdy[k]. This is allowed in any slot.
- Dequeue:
  - out_val=!empty[slot]; out_msg=head of FIFO[slot], or 0 when out_val=0.
  - Transfer occurs when out_val && out_rdy. A dequeue in the slot_last cycle pops the FIFO of the slot that is ending; the slot advances after that edge.
- Latency and bypass:
  - Minimum in-to-out latency is 1 cycle. No combinational bypass: a message enqueued at edge t is first visible at t+1.
  - Simultaneous enqueue and dequeue on a full FIFO is allowed; count is unchanged.
- Isolation:
  - State of FIFO j never influences in_rdy[k], out_val or out_msg during slot k for k!=j.
  - out_rdy in slot k affects only FIFO k.
- FIFO:
  - Circular buffer; pointers of width clog2(p_depth) wrap modulo p_depth; count of width clog2(p_depth)+1.
  - p_depth=1: single register with full flag.
- Downstream stall: an undelivered head waits for its port's next slot. There is no drop and no reordering within a port.

Optional Feature:
- Macro VC_TDM_MUX_GUARD_EN.
- When defined, the final cycle of each slot is a guard cycle:
  - out_val is forced to 0 when slot_last=1, so no dequeue can occur in that cycle.
  - Enqueue is unaffected.
  - Elaboration error if p_slot_cycles<2.
- When undefined, every cycle of the slot may dequeue, and p_slot_cycles=1 is legal.

Test Plan:
- Reset/idle: reset_n=0 for 3 cycles, then release with all in_val=0 → out_val=0 forever; out_port sequence 0,0,…(8 cycles),1,… wraps to 0 after 32 cycles; slot_last high every 8th cycle.
- Single-domain latency: port 2 sends 0xA5A5_0002 in cycle 3 while slot=0 → held; out_val=1, out_msg=0xA5A5_0002 on the first cycle of slot 2 (cycle 16); pops with out_rdy=1.
- Isolation: fill port 0 (2 entries, in_rdy[0]→0) with out_rdy=0 permanently → in_rdy[1..3] and out_val during slots 1–3 are identical to a run where port 0 is idle.
- Back-to-back/full: in slot 1, port 1 with in_val=1 continuously and out_rdy=1 → one message per cycle out for 8 cycles (7 with GUARD_EN); a full FIFO enqueues and dequeues in the same cycle with in_rdy[1]=1.
- Boundary dequeue: head present at cyc=7 of slot 3 with out_rdy=1 → popped from port 3; next cycle out_port=0 and port 3 count decremented. With GUARD_EN, out_val=0 at cyc=7 and the message remains.
- Reset mid-operation: reset_n=0 with 2 messages queued in port 1 in slot 1, cyc=4 → next cycle all in_rdy=0, out_val=0; after release, port 1 is empty, slot=0, cyc=0.
